// File: rtl/ascon_round_counter.sv
// Round sequencer for the ASCON permutation: loads a per-mode start round, steps
// to LAST_ROUND under ena_i, then gives a one-cycle done pulse before returning to idle.
module ascon_round_counter #(
  parameter int WIDTH      = 4,
  parameter int LAST_ROUND = 11,
  parameter int INIT_A     = 0,
  parameter int INIT_B     = 6,
  parameter int INIT_C     = 4
) (
  input  logic             clock_i,
  input  logic             resetb_i,
  input  logic             ena_i,
  input  logic             start_i,
  input  logic [1:0]       mode_i,
  input  logic             abort_i,
  output logic [WIDTH-1:0] count_o,
  output logic             busy_o,
  output logic             last_o,
  output logic             done_o,
  output logic             err_o
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  localparam logic [WIDTH-1:0] LP_LAST   = WIDTH'(LAST_ROUND);
  localparam logic [WIDTH-1:0] LP_INIT_A = WIDTH'(INIT_A);
  localparam logic [WIDTH-1:0] LP_INIT_B = WIDTH'(INIT_B);
  localparam logic [WIDTH-1:0] LP_INIT_C = WIDTH'(INIT_C);

  // Start rounds must lie inside the run, and the run must fit the counter.
  if (INIT_A > LAST_ROUND || INIT_B > LAST_ROUND || INIT_C > LAST_ROUND ||
      INIT_A < 0 || INIT_B < 0 || INIT_C < 0 || LAST_ROUND >= (1 << WIDTH)) begin : g_param_check
    $fatal(1, "ascon_round_counter: INIT_x <= LAST_ROUND < 2**WIDTH violated");
  end

  state_t           r_state;
  logic [WIDTH-1:0] r_count;
  logic             r_busy;
  logic             r_done;
  logic             r_err;
  logic [WIDTH-1:0] w_init;
  logic             w_at_last;

  always_comb begin
    w_init = LP_INIT_A;
    case (mode_i)
      2'b01:   w_init = LP_INIT_B;
      2'b10:   w_init = LP_INIT_C;
      default: w_init = LP_INIT_A;
    endcase
  end

  assign w_at_last = (r_count == LP_LAST);

  // Abort outranks everything but reset; DONE always exits regardless of ena_i.
  always_ff @(posedge clock_i or negedge resetb_i) begin
    if (!resetb_i) begin
      r_state <= S_IDLE;
      r_count <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else if (abort_i) begin
      r_state <= S_IDLE;
      r_count <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (ena_i && start_i) begin
            r_state <= S_RUN;
            r_count <= w_init;
            r_busy  <= 1'b1;
          end
        end
        S_RUN: begin
          if (ena_i) begin
            if (start_i) r_err <= 1'b1;
            if (w_at_last) begin
              r_state <= S_DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_count <= r_count + WIDTH'(1);
            end
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_done  <= 1'b0;
          if (start_i) r_err <= 1'b1;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign count_o = r_count;
  assign busy_o  = r_busy;
  assign last_o  = r_busy && w_at_last;
  assign done_o  = r_done;
  assign err_o   = r_err;

endmodule

// File: tb/tb_ascon_round_counter.sv
// Self-checking bench: a queue of remaining rounds serves as the reference model,
// exercised by directed scenarios and a randomized run.
module tb_ascon_round_counter;

  localparam int WIDTH = 4;
  localparam int LAST  = 11;

  logic             clock_i = 1'b0;
  logic             resetb_i;
  logic             ena_i;
  logic             start_i;
  logic [1:0]       mode_i;
  logic             abort_i;
  logic [WIDTH-1:0] count_o;
  logic             busy_o;
  logic             last_o;
  logic             done_o;
  logic             err_o;

  int nChecks = 0;
  int nPass   = 0;

  // Reference model: rounds still to execute, plus done/err/count observations.
  int q[$];
  int mCount;
  bit mDone;
  bit mErr;

  ascon_round_counter #(.WIDTH(WIDTH), .LAST_ROUND(LAST), .INIT_A(0), .INIT_B(6), .INIT_C(4)) dut (
    .clock_i (clock_i),
    .resetb_i(resetb_i),
    .ena_i   (ena_i),
    .start_i (start_i),
    .mode_i  (mode_i),
    .abort_i (abort_i),
    .count_o (count_o),
    .busy_o  (busy_o),
    .last_o  (last_o),
    .done_o  (done_o),
    .err_o   (err_o)
  );

  always #5 clock_i = ~clock_i;

  function automatic int initOf(input logic [1:0] m);
    case (m)
      2'b01:   return 6;
      2'b10:   return 4;
      default: return 0;
    endcase
  endfunction

  function automatic logic [WIDTH+3:0] expVec();
    return {WIDTH'(mCount), q.size() > 0, q.size() == 1, mDone, mErr};
  endfunction

  function automatic logic [WIDTH+3:0] obsVec();
    return {count_o, busy_o, last_o, done_o, err_o};
  endfunction

  task automatic modelReset();
    q.delete();
    mCount = 0;
    mDone  = 1'b0;
    mErr   = 1'b0;
  endtask

  task automatic modelStep(input bit ena, input bit start, input bit abort, input logic [1:0] mode);
    if (abort) begin
      modelReset();
    end else if (mDone) begin
      mDone = 1'b0;
      if (start) mErr = 1'b1;
    end else if (q.size() > 0) begin
      if (ena) begin
        if (start) mErr = 1'b1;
        void'(q.pop_front());
        if (q.size() == 0) mDone = 1'b1;
        else mCount = q[0];
      end
    end else if (ena && start) begin
      for (int r = initOf(mode); r <= LAST; r++) q.push_back(r);
      mCount = q[0];
    end
  endtask

  task automatic tick();
    @(posedge clock_i);
    if (!resetb_i) modelReset();
    else modelStep(ena_i, start_i, abort_i, mode_i);
    #1;
  endtask

  task automatic test_reset();
    resetb_i = 1'b0; ena_i = 1'b0; start_i = 1'b0; abort_i = 1'b0; mode_i = 2'b00;
    #2;
    modelReset();
    nChecks++;
    if (obsVec() !== expVec()) $display("FAIL reset obs=%h exp=%h", obsVec(), expVec());
    else nPass++;
    tick(); tick();
    resetb_i = 1'b1;
    tick();
    nChecks++;
    if (obsVec() !== expVec()) $display("FAIL reset_release obs=%h exp=%h", obsVec(), expVec());
    else nPass++;
  endtask

  task automatic test_modes();
    int n;
    for (int m = 0; m < 4; m++) begin
      mode_i = 2'(m); ena_i = 1'b1; start_i = 1'b1;
      tick();
      start_i = 1'b0;
      nChecks++;
      if (obsVec() !== expVec()) $display("FAIL mode%0d_load obs=%h exp=%h", m, obsVec(), expVec());
      else nPass++;
      n = 0;
      while (done_o !== 1'b1 && n < 40) begin
        tick(); n++;
        nChecks++;
        if (obsVec() !== expVec()) $display("FAIL mode%0d_step obs=%h exp=%h", m, obsVec(), expVec());
        else nPass++;
      end
      nChecks++;
      if (n !== LAST - initOf(2'(m)) + 1) $display("FAIL mode%0d_latency edges=%0d want=%0d", m, n, LAST - initOf(2'(m)) + 1);
      else nPass++;
      tick();
      nChecks++;
      if (obsVec() !== expVec()) $display("FAIL mode%0d_idle obs=%h exp=%h", m, obsVec(), expVec());
      else nPass++;
    end
  endtask

  task automatic test_stall();
    int edges;
    int stalled;
    mode_i = 2'b00; ena_i = 1'b1; start_i = 1'b1;
    tick();
    start_i = 1'b0;
    edges = 0; stalled = 0;
    while (done_o !== 1'b1 && edges < 40) begin
      if (busy_o === 1'b1 && count_o == 5 && stalled < 3) begin ena_i = 1'b0; stalled++; end
      else ena_i = 1'b1;
      tick(); edges++;
      nChecks++;
      if (obsVec() !== expVec()) $display("FAIL stall_step obs=%h exp=%h", obsVec(), expVec());
      else nPass++;
    end
    ena_i = 1'b1;
    nChecks++;
    if (edges !== 15) $display("FAIL stall_latency edges=%0d want=15", edges);
    else nPass++;
    tick();
  endtask

  task automatic test_err();
    int n;
    mode_i = 2'b00; ena_i = 1'b1; start_i = 1'b1;
    tick();
    start_i = 1'b0;
    n = 0;
    while (done_o !== 1'b1 && n < 40) begin
      start_i = (busy_o === 1'b1 && count_o == 3);
      tick(); n++;
      nChecks++;
      if (obsVec() !== expVec()) $display("FAIL err_run obs=%h exp=%h", obsVec(), expVec());
      else nPass++;
    end
    start_i = 1'b0;
    nChecks++;
    if (err_o !== 1'b1 || done_o !== 1'b1) $display("FAIL err_sticky err=%b done=%b want 1/1", err_o, done_o);
    else nPass++;
    tick();
    abort_i = 1'b1;
    tick();
    abort_i = 1'b0;
    nChecks++;
    if (obsVec() !== expVec() || err_o !== 1'b0) $display("FAIL err_clear obs=%h exp=%h", obsVec(), expVec());
    else nPass++;
  endtask

  task automatic test_abort();
    int n;
    mode_i = 2'b00; ena_i = 1'b1; start_i = 1'b1;
    tick();
    start_i = 1'b0; n = 0;
    while (!(busy_o === 1'b1 && count_o == 8) && n < 40) begin tick(); n++; end
    abort_i = 1'b1;
    tick();
    abort_i = 1'b0;
    nChecks++;
    if (obsVec() !== expVec() || count_o !== 4'd0 || busy_o !== 1'b0) $display("FAIL abort obs=%h exp=%h", obsVec(), expVec());
    else nPass++;
    tick();
    nChecks++;
    if (obsVec() !== expVec() || done_o !== 1'b0) $display("FAIL abort_nodone obs=%h exp=%h", obsVec(), expVec());
    else nPass++;
    start_i = 1'b1;
    tick();
    start_i = 1'b0; n = 0;
    while (!(busy_o === 1'b1 && count_o == 5) && n < 40) begin tick(); n++; end
    #2;
    resetb_i = 1'b0;
    #1;
    modelReset();
    nChecks++;
    if (obsVec() !== expVec()) $display("FAIL async_reset obs=%h exp=%h", obsVec(), expVec());
    else nPass++;
    tick();
    resetb_i = 1'b1;
    tick();
    nChecks++;
    if (obsVec() !== expVec()) $display("FAIL post_reset obs=%h exp=%h", obsVec(), expVec());
    else nPass++;
  endtask

  task automatic test_back_to_back();
    int lastDone;
    int period;
    mode_i = 2'($urandom_range(0, 3)); ena_i = 1'b1; start_i = 1'b1;
    period = LAST - initOf(mode_i) + 3;
    lastDone = -1;
    for (int i = 0; i < 40; i++) begin
      tick();
      nChecks++;
      if (obsVec() !== expVec()) $display("FAIL b2b_step i=%0d obs=%h exp=%h", i, obsVec(), expVec());
      else nPass++;
      if (done_o === 1'b1) begin
        if (lastDone >= 0) begin
          nChecks++;
          if (i - lastDone !== period) $display("FAIL b2b_period got=%0d want=%0d", i - lastDone, period);
          else nPass++;
        end
        lastDone = i;
      end
    end
    start_i = 1'b0;
    abort_i = 1'b1;
    tick();
    abort_i = 1'b0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      ena_i   = ($urandom_range(0, 9) < 8);
      start_i = ($urandom_range(0, 3) == 0);
      abort_i = ($urandom_range(0, 29) == 0);
      mode_i  = 2'($urandom_range(0, 3));
      tick();
      nChecks++;
      if (obsVec() !== expVec()) $display("FAIL random i=%0d obs=%h exp=%h", i, obsVec(), expVec());
      else nPass++;
    end
    ena_i = 1'b0; start_i = 1'b0; abort_i = 1'b0;
  endtask

  initial begin
    modelReset();
    test_reset();
    test_modes();
    test_stall();
    test_err();
    test_abort();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
